axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_pkg.sv | 11 +
 rtl/axi_if.sv | 34 +++
 rtl/axi_lite_strb_merge.sv | 17 +
 rtl/axi_lite_regfile.sv | 130 +++++++++++++
 tb/tb_axi_lite_regfile.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants: channel widths and response codes.
package axi_lite_pkg;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_if.sv
// AXI4-Lite bundle (AW/W/B/AR/R) with master and slave views.
// Handshake: a transfer happens on a rising edge where VALID && READY; once VALID
// is raised the source holds it and its payload stable until that edge.
interface axi_if;
    import axi_lite_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  bvalid;
    logic                  bready;
    resp_t                 bresp;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    resp_t                 rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_strb_merge.sv
// Byte-lane merge: each byte of the result comes from wdata where its strobe is set,
// otherwise from the old word.
module axi_lite_strb_merge
    import axi_lite_pkg::*;
(
    input  logic [AXI_DATA_W-1:0] old_word,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    output logic [AXI_DATA_W-1:0] merged
);
    always_comb begin
        merged = old_word;
        for (int k = 0; k < AXI_STRB_W; k++) begin
            if (wstrb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
        end
    end
endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers, with a flat live copy on reg_out.
// Write and read paths are independent; AW and W may arrive in either order.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_if.slave                  axi,
    output logic [NUM_REGS*32-1:0] reg_out
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [AXI_DATA_W-1:0] regs [NUM_REGS];

    logic                  aw_held;
    logic                  w_held;
    logic [AXI_ADDR_W-1:0] aw_addr_q;
    logic [AXI_DATA_W-1:0] w_data_q;
    logic [AXI_STRB_W-1:0] w_strb_q;
    logic                  bvalid_q;
    resp_t                 bresp_q;
    logic                  rvalid_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    resp_t                 rresp_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [AXI_ADDR_W-1:0] wr_addr;
    logic [AXI_DATA_W-1:0] wr_data;
    logic [AXI_STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [AXI_DATA_W-1:0] merged;
    logic                  unused_addr_bits;

    assign axi.awready = !aw_held && !bvalid_q;
    assign axi.wready  = !w_held && !bvalid_q;
    assign axi.arready = !rvalid_q || axi.rready;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    // A channel that handshakes on the commit edge is used directly, never parked.
    assign wr_addr = aw_held ? aw_addr_q : axi.awaddr;
    assign wr_data = w_held ? w_data_q : axi.wdata;
    assign wr_strb = w_held ? w_strb_q : axi.wstrb;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx = wr_addr[IDX_W+1:2];
    assign rd_idx = axi.araddr[IDX_W+1:2];
    assign wr_ok  = (wr_addr[AXI_ADDR_W-1:IDX_W+2] == '0);
    assign rd_ok  = (axi.araddr[AXI_ADDR_W-1:IDX_W+2] == '0);

    assign unused_addr_bits = ^{wr_addr[1:0], axi.araddr[1:0]};

    axi_lite_strb_merge u_merge (
        .old_word (regs[wr_idx]),
        .wdata    (wr_data),
        .wstrb    (wr_strb),
        .merged   (merged)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= axi.awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
            end
            if (bvalid_q && axi.bready) bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (commit && wr_ok) begin
            regs[wr_idx] <= merged;
        end
    end

    // Nonblocking read of regs returns the pre-commit value on a same-edge write.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? regs[rd_idx] : '0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs[g];
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized self-checking bench for axi_lite_regfile against a register-array model.
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    localparam int          N  = 8;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic           ACLK = 1'b0;
    logic           ARESETn = 1'b0;
    logic [N*32-1:0] reg_out;

    axi_if axi ();

    axi_lite_regfile #(.NUM_REGS(N), .RESET_VAL(RV)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .axi     (axi),
        .reg_out (reg_out)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [N];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*32-1:0] model_flat();
        logic [N*32-1:0] f;
        for (int i = 0; i < N; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        return a < 32'(N * 4);
    endfunction

    function automatic logic [31:0] strb_mask(logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic init_bus();
        axi.awvalid = 1'b0; axi.awaddr = '0;
        axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0;
        axi.rready  = 1'b0;
    endtask

    // Full write transaction; starts and ends at a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold, input string tag);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        resp_t exp_resp;
        axi.awaddr = $urandom;
        axi.wdata  = $urandom;
        while (!(aw_done && w_done) && cyc < 64) begin
            if (!aw_done && cyc >= aw_dly) begin axi.awvalid = 1'b1; axi.awaddr = addr; end
            if (!w_done && cyc >= w_dly) begin axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb; end
            aw_fire = axi.awvalid && axi.awready;
            w_fire  = axi.wvalid && axi.wready;
            @(negedge ACLK);
            if (aw_fire) begin aw_done = 1; axi.awvalid = 1'b0; axi.awaddr = $urandom; end
            if (w_fire) begin w_done = 1; axi.wvalid = 1'b0; axi.wdata = $urandom; end
            cyc++;
        end
        vectors++;
        if (!(aw_done && w_done)) begin
            miscompares++;
            $display("FAIL %s write handshake timeout: aw_done=%0b w_done=%0b required 1/1", tag, aw_done, w_done);
            init_bus();
            return;
        end
        exp_resp = in_rng(addr) ? RESP_OKAY : RESP_SLVERR;
        if (in_rng(addr))
            model[addr >> 2] = (model[addr >> 2] & ~strb_mask(strb)) | (data & strb_mask(strb));
        vectors++;
        if (axi.bvalid !== 1'b1) begin miscompares++; $display("FAIL %s bvalid latency: got %b required 1", tag, axi.bvalid); end
        vectors++;
        if (axi.bresp !== exp_resp) begin miscompares++; $display("FAIL %s bresp: got %b required %b", tag, axi.bresp, exp_resp); end
        vectors++;
        if (reg_out !== model_flat()) begin miscompares++; $display("FAIL %s reg_out: got %h required %h", tag, reg_out, model_flat()); end
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            vectors++;
            if (axi.bvalid !== 1'b1 || axi.bresp !== exp_resp || axi.awready !== 1'b0 || axi.wready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s b hold: bvalid=%b bresp=%b awready=%b wready=%b required 1 %b 0 0",
                         tag, axi.bvalid, axi.bresp, axi.awready, axi.wready, exp_resp);
            end
        end
        axi.bready = 1'b1;
        @(negedge ACLK);
        axi.bready = 1'b0;
        vectors++;
        if (axi.bvalid !== 1'b0) begin miscompares++; $display("FAIL %s bvalid clear: got %b required 0", tag, axi.bvalid); end
    endtask

    // Full read transaction with an optional RREADY stall; starts and ends at a falling edge.
    task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
        bit fired = 0;
        int cyc = 0;
        logic [31:0] exp_data;
        resp_t exp_resp;
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        while (!fired && cyc < 64) begin
            fired = axi.arvalid && axi.arready;
            @(negedge ACLK);
            cyc++;
        end
        axi.arvalid = 1'b0;
        axi.araddr  = $urandom;
        exp_data = in_rng(addr) ? model[addr >> 2] : 32'h0;
        exp_resp = in_rng(addr) ? RESP_OKAY : RESP_SLVERR;
        vectors++;
        if (!fired || axi.rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s rvalid: got %b required 1", tag, axi.rvalid);
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge ACLK);
            vectors++;
            if (axi.rdata !== exp_data || axi.rresp !== exp_resp || axi.rvalid !== 1'b1) begin
                miscompares++;
                $display("FAIL %s rdata/rresp: got %h/%b required %h/%b", tag, axi.rdata, axi.rresp, exp_data, exp_resp);
            end
        end
        axi.rready = 1'b1;
        @(negedge ACLK);
        axi.rready = 1'b0;
        vectors++;
        if (axi.rvalid !== 1'b0) begin miscompares++; $display("FAIL %s rvalid clear: got %b required 0", tag, axi.rvalid); end
    endtask

    task automatic test_reset();
        init_bus();
        for (int i = 0; i < N; i++) model[i] = RV;
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        vectors++;
        if (axi.awready !== 1'b1 || axi.wready !== 1'b1 || axi.arready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset readies: aw=%b w=%b ar=%b required 1 1 1", axi.awready, axi.wready, axi.arready);
        end
        vectors++;
        if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0 || axi.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset valids: bvalid=%b rvalid=%b rdata=%h required 0 0 0", axi.bvalid, axi.rvalid, axi.rdata);
        end
        vectors++;
        if (reg_out !== {N{RV}}) begin miscompares++; $display("FAIL reset reg_out: got %h required %h", reg_out, {N{RV}}); end
        ARESETn = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_same_cycle_write();
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "same_cycle");
        do_read(32'h4, 0, "same_cycle_rd");
    endtask

    task automatic test_w_first();
        do_write(32'h8, 32'h1122_3344, 4'b0101, 3, 0, 5, "w_first");
        vectors++;
        if (reg_out[95:64] !== 32'h0022_0044) begin
            miscompares++;
            $display("FAIL w_first reg2: got %h required 00220044", reg_out[95:64]);
        end
        do_read(32'h8, 2, "w_first_rd");
    endtask

    task automatic test_out_of_range();
        logic [N*32-1:0] snap;
        snap = reg_out;
        do_write(32'h20, $urandom, 4'hF, 1, 0, 0, "oor_wr");
        vectors++;
        if (reg_out !== snap) begin miscompares++; $display("FAIL oor reg_out changed: got %h required %h", reg_out, snap); end
        do_read(32'h40, 0, "oor_rd");
    endtask

    task automatic test_read_during_write();
        logic [31:0] old3;
        old3 = model[3];
        axi.awvalid = 1'b1; axi.awaddr = 32'hC;
        axi.wvalid  = 1'b1; axi.wdata  = 32'hA5A5_A5A5; axi.wstrb = 4'hF;
        axi.arvalid = 1'b1; axi.araddr = 32'hC;
        @(negedge ACLK);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        model[3] = 32'hA5A5_A5A5;
        vectors++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== old3 || axi.rresp !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL rdw old value: rvalid=%b rdata=%h required 1 %h", axi.rvalid, axi.rdata, old3);
        end
        vectors++;
        if (axi.bvalid !== 1'b1 || axi.bresp !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL rdw write resp: bvalid=%b bresp=%b required 1 00", axi.bvalid, axi.bresp);
        end
        axi.bready = 1'b1; axi.rready = 1'b1;
        @(negedge ACLK);
        axi.bready = 1'b0; axi.rready = 1'b0;
        do_read(32'hC, 0, "rdw_new");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, exp_next, exp_prev;
        exp_next = '0;
        exp_prev = '0;
        axi.rready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                vectors++;
                if (axi.rvalid !== 1'b1 || axi.rdata !== exp_prev) begin
                    miscompares++;
                    $display("FAIL b2b read %0d: rvalid=%b rdata=%h required 1 %h", i, axi.rvalid, axi.rdata, exp_prev);
                end
            end
            if (i < 6) begin
                a = 32'($urandom_range(0, N - 1)) << 2;
                axi.arvalid = 1'b1;
                axi.araddr  = a;
                exp_next = model[a >> 2];
                vectors++;
                if (axi.arready !== 1'b1) begin miscompares++; $display("FAIL b2b arready %0d: got %b required 1", i, axi.arready); end
            end else begin
                axi.arvalid = 1'b0;
            end
            @(negedge ACLK);
            exp_prev = exp_next;
        end
        axi.rready = 1'b0;
        vectors++;
        if (axi.rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b drain: rvalid=%b required 0", axi.rvalid); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(N * 4, N * 4 + 63));
            else a = 32'($urandom_range(0, N * 4 - 1));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2), "rand_wr");
            else
                do_read(a, $urandom_range(0, 2), "rand_rd");
        end
    endtask

    task automatic test_reset_midflight();
        axi.awvalid = 1'b1; axi.awaddr = 32'h4;
        @(negedge ACLK);
        axi.awvalid = 1'b0;
        axi.arvalid = 1'b1; axi.araddr = 32'h0;
        @(negedge ACLK);
        axi.arvalid = 1'b0;
        vectors++;
        if (axi.awready !== 1'b0 || axi.rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight setup: awready=%b rvalid=%b required 0 1", axi.awready, axi.rvalid);
        end
        ARESETn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model[i] = RV;
        vectors++;
        if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL async reset valids: bvalid=%b rvalid=%b required 0 0", axi.bvalid, axi.rvalid);
        end
        vectors++;
        if (reg_out !== {N{RV}}) begin miscompares++; $display("FAIL async reset reg_out: got %h required %h", reg_out, {N{RV}}); end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        axi.bready = 1'b1; axi.rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            vectors++;
            if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0 || axi.awready !== 1'b1) begin
                miscompares++;
                $display("FAIL post reset stale: bvalid=%b rvalid=%b awready=%b required 0 0 1", axi.bvalid, axi.rvalid, axi.awready);
            end
        end
        axi.bready = 1'b0; axi.rready = 1'b0;
        do_write(32'h10, $urandom, 4'hF, 0, 1, 0, "post_reset_wr");
        do_read(32'h10, 0, "post_reset_rd");
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_first();
        test_out_of_range();
        test_read_during_write();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
